imem_fetch_sequencer: RTL and testbench

IMEM_FETCH_SEQUENCER -- requirements
Module: imem_fetch_sequencer

---
 rtl/imem_fetch_sequencer.sv | 150 +++++++++++++++
 tb/tb_imem_fetch_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: arbitrates CPU instruction fetches and loader byte writes onto one
// byte-wide single-port memory. A fetch reads four bytes and returns a big-endian word in 6 cycles.
// A load writes one byte and takes 2 cycles. Neither operation is preempted.
// Optional feature: define IMEM_MISALIGN_TRAP_EN to reject misaligned fetches with fetch_err.
// Without it, fetch_addr[1:0] is ignored.
// Ports:
//   clk, rst (sync, active-high)
//   fetch_req/fetch_addr/fetch_ready
//   fetch_valid/instruction/fetch_err
//   load_req/load_addr/load_data/load_ack
//   mem_addr/mem_we/mem_wdata/mem_rdata (read data valid one cycle after address)
module imem_fetch_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] instruction,
    output logic        fetch_err,
    input  logic        load_req,
    input  logic [15:0] load_addr,
    input  logic [7:0]  load_data,
    output logic        load_ack,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [15:0] base_addr;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [23:0] byte_shift;
    logic        last_grant_fetch;
    logic        grant_fetch;
    logic        grant_load;
    logic        misaligned;
    logic        unused_addr_bits;

`ifdef IMEM_MISALIGN_TRAP_EN
    assign misaligned = (fetch_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    // Upper address bits are outside the 64 KiB memory.
    // The byte offset only matters for the trap.
    assign unused_addr_bits = ^{fetch_addr[31:16], fetch_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        fetch_ready = 1'b0;
        load_ack    = 1'b0;
        grant_fetch = 1'b0;
        grant_load  = 1'b0;
        mem_addr    = 16'h0000;
        mem_we      = 1'b0;
        mem_wdata   = 8'h00;
        case (state)
            IDLE: begin
                // On contention, the side that did not win last time is granted.
                // This makes the two grants mutually exclusive.
                fetch_ready = !load_req || !last_grant_fetch;
                load_ack    = !fetch_req || last_grant_fetch;
                grant_fetch = fetch_req && fetch_ready;
                grant_load  = load_req && load_ack;
                if (grant_fetch) begin
                    state_nxt = misaligned ? IDLE : READ;
                end else if (grant_load) begin
                    state_nxt = WRITE;
                end
            end
            READ: begin
                mem_addr = base_addr + {14'b0, cnt};
                if (cnt == 2'd3) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= 2'd0;
            last_grant_fetch <= 1'b0;
            base_addr        <= 16'h0000;
            wr_addr          <= 16'h0000;
            wr_data          <= 8'h00;
            byte_shift       <= 24'h0;
            instruction      <= 32'h0;
            fetch_valid      <= 1'b0;
            fetch_err        <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            if (grant_fetch) begin
                last_grant_fetch <= 1'b1;
                base_addr        <= {fetch_addr[15:2], 2'b00};
                cnt              <= 2'd0;
                fetch_err        <= misaligned;
            end
            if (grant_load) begin
                last_grant_fetch <= 1'b0;
                wr_addr          <= load_addr;
                wr_data          <= load_data;
            end
            if (state == READ) begin
                cnt <= cnt + 2'd1;
                // Read data trails the address by one cycle.
                // At cnt==k, the data for byte k-1 arrives.
                if (cnt != 2'd0) begin
                    byte_shift <= {byte_shift[15:0], mem_rdata};
                end
            end
            if (state == DRAIN) begin
                instruction <= {byte_shift, mem_rdata};
                fetch_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Testbench for imem_fetch_sequencer.
// Random fetch/load traffic is compared against a transaction-level model.
// The model tracks when the block is busy, who was granted last, and a reference memory image.
module tb_imem_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] instruction;
    logic        fetch_err;
    logic        load_req;
    logic [15:0] load_addr;
    logic [7:0]  load_data;
    logic        load_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    imem_fetch_sequencer dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .instruction(instruction), .fetch_err(fetch_err),
        .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Physical memory the DUT talks to, with one-cycle read latency.
    logic [7:0] env_mem [65536];
    // Reference image: updated at the moment a load is granted.
    logic [7:0] ref_mem [65536];

    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr] <= mem_wdata;
        mem_rdata <= env_mem[mem_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int free_at, fv_at, we_at, err_at, fstart;
    logic        last_fetch;
    logic [15:0] fbase, exp_waddr;
    logic [7:0]  exp_wdata;
    logic [31:0] exp_instr, pend_instr;
    logic        f_taken, l_taken, check_en;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        free_at    = cyc + 1;
        fv_at      = -1;
        we_at      = -1;
        err_at     = -1;
        fstart     = -100;
        last_fetch = 1'b0;
        exp_instr  = 32'h0;
    endtask

    task automatic cycle_begin();
        @(posedge clk);
        #1;
        cyc++;
        if (f_taken) begin fetch_req = 1'b0; f_taken = 1'b0; end
        if (l_taken) begin load_req = 1'b0; l_taken = 1'b0; end
    endtask

    task automatic cycle_end();
        logic idle, exp_af, exp_al, misal;
        logic [15:0] a;
        @(negedge clk);
        if (check_en) begin
            idle   = (cyc >= free_at);
            exp_af = idle && fetch_req && (!load_req || !last_fetch);
            exp_al = idle && load_req && (!fetch_req || last_fetch);
            if (cyc == fv_at) exp_instr = pend_instr;
            check_eq("fetch_accept", {31'b0, fetch_req && fetch_ready}, {31'b0, exp_af});
            check_eq("load_accept", {31'b0, load_req && load_ack}, {31'b0, exp_al});
            check_eq("fetch_valid", {31'b0, fetch_valid}, {31'b0, cyc == fv_at});
            check_eq("fetch_err", {31'b0, fetch_err}, {31'b0, cyc == err_at});
            check_eq("instruction", instruction, exp_instr);
            check_eq("mem_we", {31'b0, mem_we}, {31'b0, cyc == we_at});
            if (cyc == we_at) begin
                check_eq("wr_addr", {16'b0, mem_addr}, {16'b0, exp_waddr});
                check_eq("wr_data", {24'b0, mem_wdata}, {24'b0, exp_wdata});
            end else if (cyc > fstart && cyc <= fstart + 4) begin
                check_eq("rd_addr", {16'b0, mem_addr}, {16'b0, fbase + 16'(cyc - fstart - 1)});
            end else if (idle) begin
                check_eq("idle_addr", {16'b0, mem_addr}, 32'h0);
            end
            if (exp_af) begin
                f_taken    = 1'b1;
                last_fetch = 1'b1;
                a          = fetch_addr[15:0];
                misal      = 1'b0;
`ifdef IMEM_MISALIGN_TRAP_EN
                misal = (a[1:0] != 2'b00);
`endif
                if (misal) begin
                    err_at  = cyc + 1;
                    free_at = cyc + 1;
                end else begin
                    fbase      = {a[15:2], 2'b00};
                    fstart     = cyc;
                    free_at    = cyc + 6;
                    fv_at      = cyc + 6;
                    pend_instr = {ref_mem[fbase], ref_mem[fbase + 16'd1],
                                  ref_mem[fbase + 16'd2], ref_mem[fbase + 16'd3]};
                end
            end
            if (exp_al) begin
                l_taken            = 1'b1;
                last_fetch         = 1'b0;
                we_at              = cyc + 1;
                exp_waddr          = load_addr;
                exp_wdata          = load_data;
                ref_mem[load_addr] = load_data;
                free_at            = cyc + 2;
            end
        end
        if (rst) model_reset();
    endtask

    task automatic reset_value_checks();
        check_eq("rst_instr", instruction, 32'h0);
        check_eq("rst_fvalid", {31'b0, fetch_valid}, 32'h0);
        check_eq("rst_ferr", {31'b0, fetch_err}, 32'h0);
        check_eq("rst_we", {31'b0, mem_we}, 32'h0);
        check_eq("rst_addr", {16'b0, mem_addr}, 32'h0);
        check_eq("rst_wdata", {24'b0, mem_wdata}, 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        rst = 1'b1;
        fetch_req = 1'b0; fetch_addr = 32'h0;
        load_req = 1'b0; load_addr = 16'h0; load_data = 8'h0;
        f_taken = 1'b0; l_taken = 1'b0; check_en = 1'b0;
        model_reset();
        for (int i = 0; i < 65536; i++) begin
            b = 8'($urandom);
            env_mem[i] = b;
            ref_mem[i] = b;
        end
        env_mem[16'h10] = 8'h13; env_mem[16'h11] = 8'h00;
        env_mem[16'h12] = 8'h05; env_mem[16'h13] = 8'h93;
        ref_mem[16'h10] = 8'h13; ref_mem[16'h11] = 8'h00;
        ref_mem[16'h12] = 8'h05; ref_mem[16'h13] = 8'h93;

        repeat (2) begin cycle_begin(); cycle_end(); end

        // First cycle out of reset: simultaneous fetch of 0x10 and load 0x40/AB.
        cycle_begin();
        rst = 1'b0;
        check_en = 1'b1;
        reset_value_checks();
        fetch_req = 1'b1; fetch_addr = 32'h0000_0010;
        load_req = 1'b1; load_addr = 16'h0040; load_data = 8'hAB;
        cycle_end();

        for (int i = 0; i < 1500; i++) begin
            bit sat;
            int step;
            cycle_begin();
            sat = (i >= 200 && i < 260);
            if (!fetch_req) begin
                step = i;
                if (step < 40) begin
                    // Directed refetch of the loaded byte, then an unaligned fetch.
                    fetch_req  = 1'b1;
                    fetch_addr = (exp_instr == 32'h0) ? 32'hABCD_0040 : 32'h0000_0012;
                end else if (sat || $urandom_range(0, 2) == 0) begin
                    r = $urandom;
                    fetch_req  = 1'b1;
                    fetch_addr = {r[31:16], 8'h00, r[7:0]};
                end
            end
            if (!load_req && i >= 40 && (sat || $urandom_range(0, 3) == 0)) begin
                load_req  = 1'b1;
                load_addr = 16'($urandom_range(0, 255));
                load_data = 8'($urandom);
            end
            cycle_end();
        end

        // Let outstanding requests drain.
        repeat (20) begin cycle_begin(); cycle_end(); end

        // Reset in the middle of a fetch: nothing may complete afterwards.
        cycle_begin();
        fetch_req = 1'b1; fetch_addr = 32'h0000_0010;
        cycle_end();
        repeat (2) begin cycle_begin(); cycle_end(); end
        cycle_begin();
        rst = 1'b1;
        cycle_end();
        cycle_begin();
        rst = 1'b0;
        reset_value_checks();
        cycle_end();
        repeat (10) begin cycle_begin(); cycle_end(); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
